// File: rtl/rb_arbiter.sv
// rtl/rb_arbiter.sv - two-port round-robin burst arbiter in front of a single register bank
// Bank strobes are decoded from the FSM state; grant/valid/done/rdata are registered.
module rb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          rw0,
  input  logic          rw1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [4:0]    len0,
  input  logic [4:0]    len1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic          dv0,
  output logic          dv1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          RB_RW,
  output logic [AW-1:0] RB_A,
  output logic [DW-1:0] RB_D,
  input  logic [DW-1:0] RB_Q
);

  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

  state_t        r_state;
  logic          r_owner;
  logic          r_last;
  logic          r_rw;
  logic [AW-1:0] r_start;
  logic [4:0]    r_len;
  logic [4:0]    r_beat;

  logic w_pick;
  logic w_xfer;
  logic w_last;

  // On a tie the port that did not own the previous burst wins.
  assign w_pick = (req0 && req1) ? ~r_last : req1;
  assign w_xfer = (r_state == XFER);
  // len 0 wraps to 31 here, giving a 32-beat burst.
  assign w_last = (r_beat == r_len - 5'd1);

  assign ack0  = w_xfer && !r_owner;
  assign ack1  = w_xfer &&  r_owner;
  assign RB_RW = w_xfer ? r_rw : 1'b1;
  assign RB_A  = w_xfer ? r_start + AW'(r_beat) : '0;
  assign RB_D  = (w_xfer && !r_rw) ? (r_owner ? wdata1 : wdata0) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_rw    <= 1'b1;
      r_start <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      dv0     <= 1'b0;
      dv1     <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rdata   <= '0;
    end else begin
      dv0   <= 1'b0;
      dv1   <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req0 || req1) begin
            r_owner <= w_pick;
            r_rw    <= w_pick ? rw1 : rw0;
            r_start <= w_pick ? addr1 : addr0;
            r_len   <= w_pick ? len1 : len0;
            r_beat  <= '0;
            gnt0    <= ~w_pick;
            gnt1    <= w_pick;
            r_state <= XFER;
          end
        end
        XFER: begin
          r_beat <= r_beat + 5'd1;
          if (r_rw) begin
            rdata <= RB_Q;
            dv0   <= ~r_owner;
            dv1   <= r_owner;
          end
          if (w_last) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= ~r_owner;
            done1   <= r_owner;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          r_last  <= r_owner;
          r_beat  <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rb_arbiter.sv
// tb/tb_rb_arbiter.sv - self-checking bench for rb_arbiter
module tb_rb_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int MAXC = 2048;

  typedef struct packed {
    logic         drop;
    logic         rw;
    logic [4:0]   addr;
    logic [4:0]   len;
    logic [255:0] data;
  } burst_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [4:0] len0 = '0, len1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, ack0, ack1, dv0, dv1, done0, done1, RB_RW;
  logic [DW-1:0] rdata, RB_D, RB_Q;
  logic [AW-1:0] RB_A;

  logic [7:0] bank [32];
  logic [7:0] init_v [32];
  logic [7:0] mbank [32];

  burst_t q0[$], q1[$];
  logic [1:0] e_gnt [MAXC];
  logic [1:0] e_ack [MAXC];
  logic [1:0] e_dv [MAXC];
  logic [1:0] e_done [MAXC];
  logic       e_rw [MAXC];
  logic [4:0] e_a [MAXC];
  logic [7:0] e_d [MAXC];
  logic [7:0] e_rd [MAXC];
  int n_tests = 0;
  int n_fail = 0;
  int tcyc = 0;

  always #5 clk = ~clk;

  rb_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .dv0(dv0), .dv1(dv1), .done0(done0), .done1(done1),
    .rdata(rdata), .RB_RW(RB_RW), .RB_A(RB_A), .RB_D(RB_D), .RB_Q(RB_Q)
  );

  // Register bank: asynchronous read, write on the clock edge.
  assign RB_Q = bank[RB_A];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) bank[i] <= init_v[i];
    end else if (!RB_RW) begin
      bank[RB_A] <= RB_D;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic burst_t mk(input logic rw, input logic [4:0] a, input logic [4:0] l,
                                input logic [7:0] base, input logic drop);
    burst_t b;
    b.rw = rw; b.addr = a; b.len = l; b.drop = drop;
    for (int k = 0; k < 32; k++) b.data[k*8 +: 8] = base + 8'(k);
    return b;
  endfunction

  function automatic burst_t mkr();
    burst_t b;
    b.rw = 1'($urandom); b.addr = 5'($urandom); b.len = 5'($urandom);
    b.drop = ($urandom_range(0, 3) == 0);
    for (int k = 0; k < 8; k++) b.data[k*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic chk_rst(input string tag);
    chk({tag, " gnt"}, 32'({gnt1, gnt0}), 32'd0);
    chk({tag, " ack"}, 32'({ack1, ack0}), 32'd0);
    chk({tag, " dv"}, 32'({dv1, dv0}), 32'd0);
    chk({tag, " done"}, 32'({done1, done0}), 32'd0);
    chk({tag, " rdata"}, 32'(rdata), 32'd0);
    chk({tag, " RB_RW"}, 32'(RB_RW), 32'd1);
    chk({tag, " RB_A"}, 32'(RB_A), 32'd0);
    chk({tag, " RB_D"}, 32'(RB_D), 32'd0);
  endtask

  // Transaction-level timeline: a burst picked at idle cycle c owns cycles c+1..c+L,
  // releases at c+L+1 and the next arbitration happens at c+L+2.
  task automatic build();
    burst_t m0[$], m1[$];
    burst_t b;
    int c, p, lastp, len;
    logic [4:0] a;
    m0 = q0; m1 = q1; c = 0; lastp = 1;
    for (int i = 0; i < MAXC; i++) begin
      e_gnt[i] = 0; e_ack[i] = 0; e_dv[i] = 0; e_done[i] = 0;
      e_rw[i] = 1; e_a[i] = 0; e_d[i] = 0; e_rd[i] = 0;
    end
    while (m0.size() + m1.size() > 0) begin
      if (m0.size() > 0 && m1.size() > 0) p = 1 - lastp;
      else p = (m0.size() > 0) ? 0 : 1;
      b = (p == 1) ? m1.pop_front() : m0.pop_front();
      len = (b.len == 0) ? 32 : int'(b.len);
      for (int k = 0; k < len; k++) begin
        a = b.addr + 5'(k);
        e_gnt[c+1+k] = (p == 1) ? 2'b10 : 2'b01;
        e_ack[c+1+k] = (p == 1) ? 2'b10 : 2'b01;
        e_rw[c+1+k] = b.rw;
        e_a[c+1+k] = a;
        if (!b.rw) begin
          e_d[c+1+k] = b.data[k*8 +: 8];
          mbank[a] = b.data[k*8 +: 8];
        end else begin
          e_dv[c+2+k] = (p == 1) ? 2'b10 : 2'b01;
          e_rd[c+2+k] = mbank[a];
        end
      end
      e_done[c+len+1] = (p == 1) ? 2'b10 : 2'b01;
      lastp = p;
      c += len + 2;
    end
    tcyc = c;
  endtask

  task automatic start();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Requesters hold req while they have bursts queued, advance wdata after each
  // acked edge, and pop a burst when its done is seen.
  task automatic run(input int abort_cyc);
    int w0 = 0, w1 = 0;
    bit pa0 = 0, pa1 = 0, d0 = 0, d1 = 0;
    for (int i = 0; i < 32; i++) mbank[i] = bank[i];
    build();
    for (int cy = 0; cy < tcyc + 3; cy++) begin
      @(negedge clk);
      if (pa0) w0++;
      if (pa1) w1++;
      if (done0 && q0.size() > 0) begin q0.delete(0); w0 = 0; d0 = 0; end
      if (done1 && q1.size() > 0) begin q1.delete(0); w1 = 0; d1 = 0; end
      if (gnt0 && q0.size() > 0 && q0[0].drop) d0 = 1;
      if (gnt1 && q1.size() > 0 && q1[0].drop) d1 = 1;
      req0 = (q0.size() > 0) && !d0;
      req1 = (q1.size() > 0) && !d1;
      if (q0.size() > 0) begin
        rw0 = q0[0].rw; addr0 = q0[0].addr; len0 = q0[0].len;
        wdata0 = q0[0].data[(w0 % 32)*8 +: 8];
      end
      if (q1.size() > 0) begin
        rw1 = q1[0].rw; addr1 = q1[0].addr; len1 = q1[0].len;
        wdata1 = q1[0].data[(w1 % 32)*8 +: 8];
      end
      pa0 = ack0; pa1 = ack1;
      #1;
      chk($sformatf("c%0d gnt", cy), 32'({gnt1, gnt0}), 32'(e_gnt[cy]));
      chk($sformatf("c%0d ack", cy), 32'({ack1, ack0}), 32'(e_ack[cy]));
      chk($sformatf("c%0d dv", cy), 32'({dv1, dv0}), 32'(e_dv[cy]));
      chk($sformatf("c%0d done", cy), 32'({done1, done0}), 32'(e_done[cy]));
      chk($sformatf("c%0d RB_RW", cy), 32'(RB_RW), 32'(e_rw[cy]));
      chk($sformatf("c%0d RB_A", cy), 32'(RB_A), 32'(e_a[cy]));
      if (!(e_ack[cy] != 0 && e_rw[cy]))
        chk($sformatf("c%0d RB_D", cy), 32'(RB_D), 32'(e_d[cy]));
      if (e_dv[cy] != 0)
        chk($sformatf("c%0d rdata", cy), 32'(rdata), 32'(e_rd[cy]));
      if (cy == abort_cyc) begin
        rst = 1'b1;
        #1;
        chk_rst("abort");
        break;
      end
    end
    if (abort_cyc < 0) chk("drained", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    int n0, n1;
    for (int i = 0; i < 32; i++) init_v[i] = 8'($urandom);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    #1;
    chk_rst("reset");

    // Single write burst on port 0.
    q0 = {mk(1'b0, 5'd3, 5'd4, 8'hA1, 1'b0)};
    start(); run(-1);
    for (int k = 0; k < 4; k++) chk($sformatf("bank[%0d]", 3 + k), 32'(bank[3+k]), 32'(8'hA1 + 8'(k)));

    // Read burst wrapping past address 31.
    q1 = {mk(1'b1, 5'd30, 5'd4, 8'h00, 1'b0)};
    start(); run(-1);

    // Both held from reset, single-beat bursts: strict alternation starting at port 0.
    q0 = {mk(1'b1, 5'd5, 5'd1, 8'h0, 1'b0), mk(1'b1, 5'd6, 5'd1, 8'h0, 1'b0), mk(1'b1, 5'd7, 5'd1, 8'h0, 1'b0)};
    q1 = {mk(1'b0, 5'd9, 5'd1, 8'h31, 1'b0), mk(1'b0, 5'd9, 5'd1, 8'h32, 1'b0)};
    start(); run(-1);

    // len 0 read from address 0: whole bank.
    q0 = {mk(1'b1, 5'd0, 5'd0, 8'h00, 1'b0)};
    start(); run(-1);

    // Reset on beat 2 of an 8-beat write.
    q0 = {mk(1'b0, 5'd10, 5'd8, 8'h50, 1'b0)};
    start(); run(3);
    q0.delete(); req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk_rst("in reset");
    rst = 1'b0;
    chk("abort bank[10]", 32'(bank[10]), 32'h50);
    chk("abort bank[11]", 32'(bank[11]), 32'h51);
    chk("abort bank[12]", 32'(bank[12]), 32'(init_v[12]));
    q0 = {mk(1'b0, 5'd12, 5'd2, 8'h60, 1'b0)};
    q1 = {mk(1'b1, 5'd12, 5'd1, 8'h00, 1'b0)};
    run(-1);

    for (int it = 0; it < 8; it++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range((n0 == 0) ? 1 : 0, 3);
      for (int j = 0; j < n0; j++) q0.push_back(mkr());
      for (int j = 0; j < n1; j++) q1.push_back(mkr());
      start(); run(-1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rb_arbiter.md
RB_ARBITER -- requirements
Module: rb_arbiter

Interface
REQ-001 SHALL expose parameter AW, default 5, meaning register-bank address width (32 entries).
REQ-002 SHALL expose parameter DW, default 8, meaning register-bank data width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0/req1  input  1 each  access request from port 0/1.
REQ-006 SHALL have ports rw0/rw1  input  1 each  burst direction, 1 = read, 0 = write.
REQ-007 SHALL have ports addr0/addr1  input  AW each  burst start address.
REQ-008 SHALL have ports len0/len1  input  5 each  burst length in beats; 0 encodes 32.
REQ-009 SHALL have ports wdata0/wdata1  input  DW each  write data for the current beat.
REQ-010 SHALL have ports gnt0/gnt1  output  1 each  grant, high for the whole owned burst.
REQ-011 SHALL have ports ack0/ack1  output  1 each  beat strobe, high in every cycle a beat is issued to the bank.
REQ-012 SHALL have ports dv0/dv1  output  1 each  read-data valid, one cycle per read beat.
REQ-013 SHALL have ports done0/done1  output  1 each  one-cycle burst-complete pulse.
REQ-014 SHALL have port rdata  output  DW  registered read data, shared by both ports.
REQ-015 SHALL have ports RB_RW  output  1 (1 = read), RB_A  output  AW, RB_D  output  DW: bank control and write data.
REQ-016 SHALL have port RB_Q  input  DW  bank read data; the bank read is asynchronous, so RB_Q is valid in the same cycle as RB_A.

Function
REQ-017 SHALL implement FSM states IDLE, XFER and RELEASE.
REQ-018 IDLE: when any req is high at the clock edge, SHALL select the owner, latch its rw/addr/len, assert its gnt and go to XFER; gnt rises one cycle after req is sampled.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests the port not granted most recently wins; after reset, port 0 has priority.
REQ-020 Requesters SHALL hold rw/addr/len stable while req is high and gnt is low; values are not sampled after grant.
REQ-021 XFER: each cycle SHALL drive RB_A = (start + beat) mod 2^AW, RB_RW = latched rw and ackN = 1 for the owner, and SHALL increment the beat counter.
REQ-022 Address SHALL wrap from 31 to 0 within a burst.
REQ-023 Write beats: RB_D SHALL combinationally equal the owner's wdata while RB_RW = 0; the requester advances wdata after each edge where ack was high.
REQ-024 Read beats: rdata SHALL register RB_Q at the end of each XFER read cycle; the owner's dv is high in the following cycle.
REQ-025 Last beat: when beat = len-1 (31 for len = 0), SHALL move to RELEASE.
REQ-026 RELEASE: SHALL deassert gnt, pulse the owner's doneN for one cycle, update the round-robin pointer, drive RB_RW = 1 and return to IDLE; the last read dv coincides with done.
REQ-027 A req still high in IDLE after done SHALL be treated as a new request; the other port, if requesting, wins per REQ-019.
REQ-028 Outside XFER: RB_RW = 1, RB_A = 0, RB_D = 0, and all ack = 0.
REQ-029 A non-owner's gnt/ack/dv/done SHALL stay 0; at most one gnt is high at any time.
REQ-030 A requester dropping req during its own burst SHALL NOT abort the burst.

Reset
REQ-031 rst SHALL asynchronously force state IDLE, pointer to port 0 priority, beat counter 0, and gnt/ack/dv/done = 0, rdata = 0, RB_RW = 1, RB_A = 0, RB_D = 0.
REQ-032 Reset mid-burst SHALL abort the burst with no done pulse; arbitration restarts cleanly after rst falls.

Verification
REQ-033 req0 write, addr 3, len 4, wdata 0xA1..0xA4 -> gnt0 next cycle; RB_A 3,4,5,6 with RB_RW = 0; ack0 ×4; done0 pulse; bank holds 0xA1..0xA4.
REQ-034 req1 read, addr 30, len 4 -> RB_A 30,31,0,1; dv1 ×4 lagging one cycle; rdata matches bank.
REQ-035 req0 and req1 both high from reset, each len 1 -> port 0, then port 1, then port 0 again while both are held.
REQ-036 len 0 read at addr 0 -> 32 beats covering 0..31, 32 dv pulses, a single done.
REQ-037 rst asserted on beat 2 of an 8-beat write -> outputs at reset values immediately, no done; next request is granted normally.
